// File: rtl/score_tracker_if.sv
// Row-clear handshake plus published game statistics between the clear block
// and the score tracker.
interface score_tracker_if;
    logic        new_game;
    logic        done_clear;
    logic [2:0]  score_cnt;
    logic [23:0] score_bcd;
    logic [9:0]  lines_total;
    logic [3:0]  level;
    logic [25:0] drop_period;
    logic        busy;
    logic        score_update;
    logic        level_up;

    modport master (
        output new_game, done_clear, score_cnt,
        input  score_bcd, lines_total, level, drop_period, busy, score_update, level_up
    );

    modport slave (
        input  new_game, done_clear, score_cnt,
        output score_bcd, lines_total, level, drop_period, busy, score_update, level_up
    );
endinterface

// File: rtl/score_tracker.sv
// Converts finished clear rounds into BCD score, line count, level and the
// gravity drop period; one BCD partial add per cycle, 1-deep pending trigger.
module score_tracker #(
    parameter int unsigned BASE_PERIOD = 50_000_000,
    parameter int unsigned PERIOD_STEP = 3_000_000
) (
    input  logic            clk,
    input  logic            rst,
    score_tracker_if.slave  bus
);
    // state  | meaning
    // IDLE   | waiting for a trigger or serving the pending entry
    // ADD    | adding the base points once per cycle, level+1 times
    // LINES  | line count / level update, score_update pulse
    typedef enum logic [1:0] {S_IDLE, S_ADD, S_LINES} state_t;

    localparam logic [25:0] BASE_P = 26'(BASE_PERIOD);
    localparam logic [25:0] STEP_P = 26'(PERIOD_STEP);

    state_t      state_q, state_d;
    logic        done_q;
    logic [2:0]  n_q, n_d;
    logic [15:0] base_q, base_d;
    logic [3:0]  iter_q, iter_d;
    logic        pend_q, pend_d;
    logic [2:0]  pend_n_q, pend_n_d;
    logic [23:0] score_q, score_d;
    logic [9:0]  lines_q, lines_d;
    logic [3:0]  mod_q, mod_d;
    logic [3:0]  level_q, level_d;
    logic [25:0] drop_q;
    logic        upd_q, upd_d;
    logic        lvlup_q, lvlup_d;

    logic        trig_valid;
    logic [2:0]  n_in;
    logic [24:0] add_r;
    logic [9:0]  lines_sum;
    logic [3:0]  mod_sum;
    logic        start;
    logic [2:0]  start_n;

    function automatic logic [15:0] base_of(input logic [2:0] n);
        case (n)
            3'd1:    base_of = 16'h0040;
            3'd2:    base_of = 16'h0100;
            3'd3:    base_of = 16'h0300;
            default: base_of = 16'h1200;
        endcase
    endfunction

    // Returns {carry_out_of_msd, sum}
    function automatic logic [24:0] bcd_add(input logic [23:0] a, input logic [23:0] b);
        logic [4:0]  s;
        logic        c;
        logic [23:0] r;
        c = 1'b0;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
            if (s > 5'd9) begin
                s = s - 5'd10;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*i +: 4] = s[3:0];
        end
        bcd_add = {c, r};
    endfunction

    assign n_in       = (bus.score_cnt > 3'd4) ? 3'd4 : bus.score_cnt;
    assign trig_valid = bus.done_clear & ~done_q & (n_in != 3'd0);
    assign add_r      = bcd_add(score_q, {8'h00, base_q});
    assign lines_sum  = lines_q + 10'(n_q);
    assign mod_sum    = mod_q + {1'b0, n_q};

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        base_d   = base_q;
        iter_d   = iter_q;
        pend_d   = pend_q;
        pend_n_d = pend_n_q;
        score_d  = score_q;
        lines_d  = lines_q;
        mod_d    = mod_q;
        level_d  = level_q;
        upd_d    = 1'b0;
        lvlup_d  = 1'b0;
        start    = 1'b0;
        start_n  = n_in;

        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    start    = 1'b1;
                    start_n  = pend_n_q;
                    pend_d   = trig_valid;
                    pend_n_d = trig_valid ? n_in : pend_n_q;
                end else if (trig_valid) begin
                    start = 1'b1;
                end
            end
            S_ADD: begin
                if (add_r[24]) begin
                    score_d = 24'h999999;
                    state_d = S_LINES;
                end else begin
                    score_d = add_r[23:0];
                    if (iter_q == 4'd0) begin
                        state_d = S_LINES;
                    end else begin
                        iter_d = iter_q - 4'd1;
                    end
                end
            end
            S_LINES: begin
                lines_d = (lines_sum > 10'd999) ? 10'd999 : lines_sum;
                if (mod_sum >= 4'd10) begin
                    mod_d = mod_sum - 4'd10;
                    if (level_q != 4'd15) begin
                        level_d = level_q + 4'd1;
                        lvlup_d = 1'b1;
                    end
                end else begin
                    mod_d = mod_sum;
                end
                upd_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && trig_valid && !pend_q) begin
            pend_d   = 1'b1;
            pend_n_d = n_in;
        end

        // Iteration count uses the level held before this clear is applied
        if (start) begin
            n_d     = start_n;
            base_d  = base_of(start_n);
            iter_d  = level_q;
            state_d = S_ADD;
        end
    end

    always_ff @(posedge clk) begin
        done_q <= bus.done_clear;
        if (rst || bus.new_game) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            base_q   <= '0;
            iter_q   <= '0;
            pend_q   <= 1'b0;
            pend_n_q <= '0;
            score_q  <= '0;
            lines_q  <= '0;
            mod_q    <= '0;
            level_q  <= '0;
            drop_q   <= BASE_P;
            upd_q    <= 1'b0;
            lvlup_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            base_q   <= base_d;
            iter_q   <= iter_d;
            pend_q   <= pend_d;
            pend_n_q <= pend_n_d;
            score_q  <= score_d;
            lines_q  <= lines_d;
            mod_q    <= mod_d;
            level_q  <= level_d;
            drop_q   <= BASE_P - 26'(level_q) * STEP_P;
            upd_q    <= upd_d;
            lvlup_q  <= lvlup_d;
        end
    end

    assign bus.score_bcd    = score_q;
    assign bus.lines_total  = lines_q;
    assign bus.level        = level_q;
    assign bus.drop_period  = drop_q;
    assign bus.busy         = (state_q != S_IDLE) | upd_q;
    assign bus.score_update = upd_q;
    assign bus.level_up     = lvlup_q;
endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker: a decimal model pushes expected statistics
// per clear and each score_update pops and compares them.
module tb_score_tracker;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    score_tracker_if bus ();

    score_tracker #(.BASE_PERIOD(50_000_000), .PERIOD_STEP(3_000_000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [23:0] score;
        logic [9:0]  lines;
        logic [3:0]  level;
        logic        lvl_up;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int m_score, m_lines, m_level, m_mod;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int x;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_score = 0; m_lines = 0; m_level = 0; m_mod = 0;
        sb.delete();
    endtask

    task automatic push_expect(input int cnt);
        exp_t e;
        int n, base, adds;
        n = (cnt > 4) ? 4 : cnt;
        base = (n == 1) ? 40 : (n == 2) ? 100 : (n == 3) ? 300 : 1200;
        adds = m_level + 1;
        for (int a = 0; a < m_level + 1; a++) begin
            m_score += base;
            if (m_score > 999999) begin
                m_score = 999999;
                adds = a + 1;
                break;
            end
        end
        m_lines = (m_lines + n > 999) ? 999 : m_lines + n;
        m_mod += n;
        e.lvl_up = 1'b0;
        if (m_mod >= 10) begin
            m_mod -= 10;
            if (m_level < 15) begin
                m_level++;
                e.lvl_up = 1'b1;
            end
        end
        e.score = to_bcd(m_score);
        e.lines = 10'(m_lines);
        e.level = 4'(m_level);
        e.lat   = adds + 2;
        sb.push_back(e);
    endtask

    // Counts negedges from the call until score_update is seen, then scores it
    task automatic wait_update(output int lat, output int exp_lat);
        exp_t e;
        logic found;
        found = 1'b0;
        lat = 0;
        exp_lat = -1;
        for (int c = 1; c <= 200 && !found; c++) begin
            @(negedge clk);
            if (bus.score_update === 1'b1) begin
                found = 1'b1;
                lat = c;
            end
        end
        chk("update_seen", {31'b0, found}, 32'd1);
        if (found) begin
            chk("sb_nonempty", {31'b0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                exp_lat = e.lat;
                chk("sb_score", bus.score_bcd, e.score);
                chk("sb_lines", bus.lines_total, e.lines);
                chk("sb_level", bus.level, e.level);
                chk("sb_level_up", bus.level_up, e.lvl_up);
            end
        end
    endtask

    task automatic do_clear(input int cnt);
        int lat, exp_lat;
        @(negedge clk);
        bus.done_clear = 1'b0;
        @(negedge clk);
        bus.score_cnt  = 3'(cnt);
        bus.done_clear = 1'b1;
        push_expect(cnt);
        wait_update(lat, exp_lat);
        chk("latency", lat, exp_lat);
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
        model_reset();
    endtask

    initial begin
        int lat, exp_lat, cnt;
        rst = 1'b1;
        bus.new_game   = 1'b0;
        bus.done_clear = 1'b0;
        bus.score_cnt  = 3'd0;
        model_reset();

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_score", bus.score_bcd, 24'h0);
        chk("rst_lines", bus.lines_total, 10'd0);
        chk("rst_level", bus.level, 4'd0);
        chk("rst_drop", bus.drop_period, 26'd50_000_000);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_update", bus.score_update, 1'b0);
        chk("rst_level_up", bus.level_up, 1'b0);
        rst = 1'b0;

        // Single line at level 0, then hold done_clear high
        @(negedge clk);
        bus.score_cnt  = 3'd1;
        bus.done_clear = 1'b1;
        push_expect(1);
        @(negedge clk);
        chk("busy_after_capture", bus.busy, 1'b1);
        wait_update(lat, exp_lat);
        chk("single_latency", lat, 32'd2);
        chk("single_score", bus.score_bcd, 24'h000040);
        chk("single_lines", bus.lines_total, 10'd1);
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.score_update === 1'b1) cnt++;
        end
        chk("held_no_retrigger", cnt, 32'd0);
        chk("idle_after_hold", bus.busy, 1'b0);

        // Level-up on the 10th single-line clear
        pulse_new_game();
        chk("new_game_score", bus.score_bcd, 24'h0);
        for (int i = 1; i <= 10; i++) do_clear(1);
        chk("level_up_10th", bus.level_up, 1'b1);
        @(negedge clk);
        chk("lvl1_level", bus.level, 4'd1);
        chk("lvl1_drop", bus.drop_period, 26'd47_000_000);
        chk("lvl1_score", bus.score_bcd, 24'h000400);

        // Four lines at level 2
        for (int i = 1; i <= 10; i++) do_clear(1);
        chk("lvl2_level", bus.level, 4'd2);
        chk("pre4_score", bus.score_bcd, 24'h001200);
        do_clear(4);
        chk("four_score", bus.score_bcd, 24'h004800);
        chk("four_lines", bus.lines_total, 10'd24);

        // new_game during ADD aborts without an update
        @(negedge clk);
        bus.done_clear = 1'b0;
        @(negedge clk);
        bus.score_cnt  = 3'd1;
        bus.done_clear = 1'b1;
        @(negedge clk);
        chk("abort_busy", bus.busy, 1'b1);
        @(negedge clk);
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
        model_reset();
        chk("abort_score", bus.score_bcd, 24'h0);
        chk("abort_lines", bus.lines_total, 10'd0);
        chk("abort_level", bus.level, 4'd0);
        chk("abort_busy_low", bus.busy, 1'b0);
        chk("abort_no_pulse", bus.score_update, 1'b0);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.score_update === 1'b1) cnt++;
        end
        chk("abort_quiet", cnt, 32'd0);
        chk("abort_drop", bus.drop_period, 26'd50_000_000);

        // Zero-row trigger
        @(negedge clk);
        bus.done_clear = 1'b0;
        @(negedge clk);
        bus.score_cnt  = 3'd0;
        bus.done_clear = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.score_update === 1'b1 || bus.busy === 1'b1) cnt++;
        end
        chk("zero_rows_quiet", cnt, 32'd0);

        // Second trigger while busy is held pending and served afterwards
        @(negedge clk);
        bus.done_clear = 1'b0;
        @(negedge clk);
        bus.score_cnt  = 3'd1;
        bus.done_clear = 1'b1;
        push_expect(1);
        @(negedge clk);
        bus.done_clear = 1'b0;
        @(negedge clk);
        bus.score_cnt  = 3'd2;
        bus.done_clear = 1'b1;
        push_expect(2);
        wait_update(lat, exp_lat);
        chk("pend_first_lat", lat, 32'd1);
        wait_update(lat, exp_lat);
        chk("pend_second_lat", lat, 32'd3);
        chk("pend_score", bus.score_bcd, 24'h000140);
        chk("pend_lines", bus.lines_total, 10'd3);

        // Saturation of score, lines and level (count 7 treated as 4)
        pulse_new_game();
        for (int i = 0; i < 250; i++) do_clear((i % 2 == 1) ? 7 : 4);
        chk("sat_score", bus.score_bcd, 24'h999999);
        chk("sat_lines", bus.lines_total, 10'd999);
        chk("sat_level", bus.level, 4'd15);
        do_clear(4);
        chk("sat_score_hold", bus.score_bcd, 24'h999999);
        @(negedge clk);
        chk("sat_drop", bus.drop_period, 26'd5_000_000);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/score_tracker.md
# score_tracker

Consumer side of the row-clear handshake. Samples the cleared-row count when the clear block raises `done_clear` and converts it to game statistics.
- Adds level-weighted points to a 6-digit BCD score, one partial add per cycle.
- Counts cleared lines and derives the level from them.
- Publishes the gravity drop period for the current level to the piece-fall timer.

## Interface
Parameters:
- `BASE_PERIOD`, 50_000_000: drop period at level 0, in clk cycles.
- `PERIOD_STEP`, 3_000_000: period reduction per level.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `new_game` in 1: one-cycle pulse; clears all statistics (same effect as reset).
- `done_clear` in 1: level from the clear block; high after a clear round ends, low again when the next round starts.
- `score_cnt` in 3: rows removed in the finished round; valid while `done_clear` is high.
- `score_bcd` out 24: score, 6 BCD digits, `[23:20]` is the MSD.
- `lines_total` out 10: binary count of cleared lines, saturates at 999.
- `level` out 4: current level, 0..15.
- `drop_period` out 26: `BASE_PERIOD - level*PERIOD_STEP`.
- `busy` out 1: high while an update is in progress.
- `score_update` out 1: one-cycle pulse when an update completes.
- `level_up` out 1: one-cycle pulse, coincident with `score_update`, when `level` increments.

## Operation
- Trigger: rising edge of `done_clear`, detected against a registered copy `done_d`. A held level never retriggers.
- Row count: captured as `n = min(score_cnt, 4)`.
  - `n == 0`: no update, no pulses.
- Base points (BCD): 1→0040, 2→0100, 3→0300, 4→1200.
- FSM states: IDLE, ADD, LINES.
  - IDLE: on a trigger with n>0:
    - latch `n` and the base value;
    - set `iter = level` (4-bit, counts down);
    - go to ADD; `busy` rises.
  - ADD: each cycle, score = score + base.
    - Carry is a full per-digit BCD chain (digit>9 → subtract 10, carry 1).
    - Carry out of digit 5: set score to 999999, go to LINES.
    - Otherwise, if `iter == 0`, go to LINES; else decrement `iter`.
    - Total adds = level+1, using the level held before this clear.
  - LINES: in a single cycle:
    - `lines_total += n` (saturate at 999);
    - update `lines_mod` (0..9 remainder counter);
    - on wrap past 9, if `level < 15`, increment `level` and pulse `level_up`;
    - pulse `score_update`; return to IDLE.
- Pending trigger: a trigger arriving while `busy` sets a 1-deep pending flag and latches its `n`.
  - IDLE serves the pending entry on the cycle after returning from LINES.
  - Further triggers while pending is full are dropped.
- `drop_period` is registered and updated in the cycle after `level` changes.
- `new_game` or `rst` takes effect at the next edge:
  - aborts any FSM state to IDLE and clears pending;
  - zeroes score, lines, `lines_mod` and level;
  - `done_d` takes the current `done_clear`, so a level that is already high does not trigger.

## Timing
- Reset values:
  - `score_bcd` 0, `lines_total` 0, `level` 0;
  - `drop_period` = `BASE_PERIOD`;
  - `busy`, `score_update`, `level_up` = 0; state IDLE; pending 0.
- Sequence, with edge k being the first edge that sees `done_clear=1` while `done_d=0`:
  - Edge k: capture; state ADD.
  - Edges k+1 .. k+L+1: the adds, with L = level.
  - Edge k+L+2: LINES update; `score_update` high for the following cycle.
  - Edge k+L+3: `busy` low; `drop_period` reflects the new level.
- Saturation ends ADD early; LINES still executes on the following edge.
- A trigger at the same edge as `new_game`: the reset wins and the trigger is ignored.

## Test plan
- Reset check:
  - Assert `rst` 2 cycles → all outputs at reset values, `drop_period` = 50_000_000.
- Single line at level 0:
  - `score_cnt`=1, raise `done_clear` → `score_bcd` = 0x000040 and `lines_total` = 1.
  - `score_update` pulses exactly 2 edges after capture.
  - Holding `done_clear` high for 100 cycles gives no second update.
- Four lines at level 2:
  - Preload via 20 single-line clears, then `score_cnt`=4 → score increases by 3600 (BCD).
  - 3 ADD cycles.
  - `lines_total` = 24.
- Level-up:
  - Ten single-line clears from reset → `level_up` pulse on the 10th.
  - `level` = 1, `drop_period` = 47_000_000, `score_bcd` = 0x000400.
- Saturation:
  - Drive repeated 4-line clears until the score exceeds 998800 → `score_bcd` = 0x999999 and stays there.
  - `lines_total` saturates at 999.
  - `level` caps at 15, with `drop_period` = 5_000_000.
- Abort and edge cases:
  - `new_game` during ADD → next cycle everything is zero, `busy`=0, no `score_update`.
  - `score_cnt`=0 trigger → no pulse.
  - Second trigger while busy → served after the first, both counted.
